// File: rtl/regfile_cr_pkg.sv
// Shared types and geometry helpers for the banked SIMD register file.
package regfile_cr_pkg;

    localparam int DEF_N       = 16;
    localparam int DEF_W       = 32;
    localparam int DEF_REGN    = 512;
    localparam int DEF_B_START = 256;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        LAST
    } state_e;

    typedef logic [DEF_N-1:0][DEF_W-1:0] row_t;

    function automatic int calcRows(input int bStart, input int n);
        return bStart / n;
    endfunction

    function automatic int calcIdep(input int regn, input int bStart);
        return regn - bStart;
    endfunction

endpackage

// File: rtl/regfile_cr_banked_if.sv
// Load, read, instruction and matrix-stream signals of the banked register file.
interface regfile_cr_banked_if
    import regfile_cr_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int W    = DEF_W,
    parameter int ROWS = calcRows(DEF_B_START, DEF_N),
    parameter int IDEP = calcIdep(DEF_REGN, DEF_B_START)
) ();

    localparam int RW = $clog2(ROWS);
    localparam int IW = $clog2(IDEP);

    logic                  WR_EN;
    logic [RW-1:0]         WR_ROW;
    logic [N-1:0][W-1:0]   WR_DATA;
    logic                  INS_WE;
    logic [IW-1:0]         INS_WADDR;
    logic [W-1:0]          INS_WDATA;
    logic [RW-1:0]         SEQ_DATC;
    logic                  RD_EN;
    logic [IW-1:0]         SEQ_INS;
    logic                  INS_RD;
    logic                  SWAP;
    logic                  STRM_START;
    logic                  MAT_READY;
    logic [N-1:0][W-1:0]   MAT_IN;
    logic                  MAT_VALID;
    logic [W-1:0]          INS_OUT;
    logic                  INS_VALID;
    logic                  STRM_BUSY;
    logic                  STRM_DONE;
    logic                  ACT_BANK;

    modport master (
        output WR_EN, WR_ROW, WR_DATA, INS_WE, INS_WADDR, INS_WDATA,
               SEQ_DATC, RD_EN, SEQ_INS, INS_RD, SWAP, STRM_START, MAT_READY,
        input  MAT_IN, MAT_VALID, INS_OUT, INS_VALID, STRM_BUSY, STRM_DONE, ACT_BANK
    );

    modport slave (
        input  WR_EN, WR_ROW, WR_DATA, INS_WE, INS_WADDR, INS_WDATA,
               SEQ_DATC, RD_EN, SEQ_INS, INS_RD, SWAP, STRM_START, MAT_READY,
        output MAT_IN, MAT_VALID, INS_OUT, INS_VALID, STRM_BUSY, STRM_DONE, ACT_BANK
    );

endinterface

// File: rtl/regfile_cr_seq.sv
// Row sequencer: manual/streamed row selection, valid/ready handshake and bank swap control.
module regfile_cr_seq
    import regfile_cr_pkg::*;
#(
    parameter int ROWS = 16,
    localparam int RW  = $clog2(ROWS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          strmStart_i,
    input  logic          rdEn_i,
    input  logic [RW-1:0] rdRow_i,
    input  logic          matReady_i,
    input  logic          swap_i,
    output logic          loadEn_o,
    output logic [RW-1:0] loadRow_o,
    output logic          matValid_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          actBank_o
);

    state_e        state_q;
    logic [RW-1:0] cnt_q;
    logic          matValid_q;
    logic          done_q;
    logic          swapPend_q;
    logic          actBank_q;
    logic          swapNow;

    // A swap landing on the edge a stream starts is deferred so every streamed row comes from one bank.
    assign swapNow = (swap_i || swapPend_q) && (state_q == IDLE) && !matValid_q && !strmStart_i;

    always_comb begin
        loadEn_o  = 1'b0;
        loadRow_o = rdRow_i;
        case (state_q)
            IDLE: begin
                if (strmStart_i) begin
                    loadEn_o  = 1'b1;
                    loadRow_o = '0;
                end else if (rdEn_i) begin
                    loadEn_o  = 1'b1;
                end
            end
            STREAM: begin
                if (matValid_q && matReady_i) begin
                    loadEn_o  = 1'b1;
                    loadRow_o = cnt_q + RW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            matValid_q <= 1'b0;
            done_q     <= 1'b0;
            swapPend_q <= 1'b0;
            actBank_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (strmStart_i) begin
                        state_q    <= STREAM;
                        cnt_q      <= '0;
                        matValid_q <= 1'b1;
                    end else if (rdEn_i) begin
                        matValid_q <= 1'b1;
                    end else if (matReady_i) begin
                        matValid_q <= 1'b0;
                    end
                end
                STREAM: begin
                    if (matValid_q && matReady_i) begin
                        cnt_q <= cnt_q + RW'(1);
                        if (cnt_q == RW'(ROWS - 2)) begin
                            state_q <= LAST;
                        end
                    end
                end
                LAST: begin
                    if (matValid_q && matReady_i) begin
                        matValid_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (swapNow) begin
                actBank_q  <= ~actBank_q;
                swapPend_q <= 1'b0;
            end else if (swap_i) begin
                swapPend_q <= 1'b1;
            end
        end
    end

    assign matValid_o = matValid_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign actBank_o  = actBank_q;

endmodule

// File: rtl/regfile_cr_banked.sv
// Double-banked row store plus instruction store feeding the SIMD matrix unit.
module regfile_cr_banked
    import regfile_cr_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int W        = DEF_W,
    parameter int REGN     = DEF_REGN,
    parameter int B_START  = DEF_B_START,
    localparam int ROWS    = calcRows(B_START, N),
    localparam int IDEP    = calcIdep(REGN, B_START)
) (
    input  logic             CLK,
    input  logic             RSTN,
    regfile_cr_banked_if.slave bus
);

    if ((B_START % N) != 0 || ROWS < 2 || IDEP < 2) begin : gIllegalGeometry
        $error("regfile_cr_banked: B_START must be a multiple of N with ROWS >= 2 and IDEP >= 2");
    end

    logic [N-1:0][W-1:0]     bank_q [2][ROWS];
    logic [W-1:0]            insMem_q [IDEP];
    logic [N-1:0][W-1:0]     matIn_q;
    logic [W-1:0]            insOut_q;
    logic                    insValid_q;
    logic                    loadEn;
    logic [$clog2(ROWS)-1:0] loadRow;
    logic                    actBank;

    regfile_cr_seq #(.ROWS(ROWS)) uSeq (
        .clk_i       (CLK),
        .rst_i       (RSTN),
        .strmStart_i (bus.STRM_START),
        .rdEn_i      (bus.RD_EN),
        .rdRow_i     (bus.SEQ_DATC),
        .matReady_i  (bus.MAT_READY),
        .swap_i      (bus.SWAP),
        .loadEn_o    (loadEn),
        .loadRow_o   (loadRow),
        .matValid_o  (bus.MAT_VALID),
        .busy_o      (bus.STRM_BUSY),
        .done_o      (bus.STRM_DONE),
        .actBank_o   (actBank)
    );

    // Reads sample the pre-edge contents, so a same-cycle write to the read address returns the old word.
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    bank_q[b][r] <= '0;
                end
            end
            for (int i = 0; i < IDEP; i++) begin
                insMem_q[i] <= '0;
            end
            matIn_q    <= '0;
            insOut_q   <= '0;
            insValid_q <= 1'b0;
        end else begin
            if (bus.WR_EN) begin
                bank_q[~actBank][bus.WR_ROW] <= bus.WR_DATA;
            end
            if (bus.INS_WE) begin
                insMem_q[bus.INS_WADDR] <= bus.INS_WDATA;
            end
            if (bus.INS_RD) begin
                insOut_q <= insMem_q[bus.SEQ_INS];
            end
            insValid_q <= bus.INS_RD;
            if (loadEn) begin
                matIn_q <= bank_q[actBank][loadRow];
            end
        end
    end

    assign bus.MAT_IN    = matIn_q;
    assign bus.INS_OUT   = insOut_q;
    assign bus.INS_VALID = insValid_q;
    assign bus.ACT_BANK  = actBank;

endmodule

// File: tb/tb_regfile_cr_banked.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_regfile_cr_banked;
    import regfile_cr_pkg::*;

    localparam int N    = DEF_N;
    localparam int W    = DEF_W;
    localparam int ROWS = calcRows(DEF_B_START, DEF_N);
    localparam int IDEP = calcIdep(DEF_REGN, DEF_B_START);
    localparam int RW   = $clog2(ROWS);
    localparam int IW   = $clog2(IDEP);

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   numAsserts = 0;
    int   numFails   = 0;
    bit   checkEn    = 1'b0;

    always #5 clock = ~clock;

    regfile_cr_banked_if #(.N(N), .W(W), .ROWS(ROWS), .IDEP(IDEP)) bus ();

    regfile_cr_banked #(.N(N), .W(W), .REGN(DEF_REGN), .B_START(DEF_B_START)) dut (
        .CLK  (clock),
        .RSTN (reset),
        .bus  (bus)
    );

    // Reference model: banks as arrays, a running stream is a snapshot queue of the active bank's rows.
    row_t       mBank [2][ROWS];
    logic [W-1:0] mIns [IDEP];
    row_t       streamQ [$];
    row_t       mMatIn;
    logic       mMatValid, mDone, mAct, mPend, mInsValid;
    logic [W-1:0] mInsOut;

    function automatic row_t fillRow(input logic [W-1:0] v);
        row_t r;
        for (int l = 0; l < N; l++) r[l] = v;
        return r;
    endfunction

    task automatic modelStep();
        logic idleFree;
        logic nextAct;
        if (reset) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < ROWS; r++) mBank[b][r] = '0;
            for (int i = 0; i < IDEP; i++) mIns[i] = '0;
            streamQ.delete();
            mMatIn = '0; mMatValid = 0; mDone = 0; mAct = 0; mPend = 0;
            mInsValid = 0; mInsOut = '0;
        end else begin
            idleFree = (streamQ.size() == 0) && !mMatValid;
            nextAct  = mAct;
            mDone    = 0;
            if (streamQ.size() != 0) begin
                if (bus.MAT_READY) begin
                    void'(streamQ.pop_front());
                    if (streamQ.size() == 0) begin
                        mMatValid = 0;
                        mDone     = 1;
                    end else begin
                        mMatIn = streamQ[0];
                    end
                end
            end else if (bus.STRM_START) begin
                for (int r = 0; r < ROWS; r++) streamQ.push_back(mBank[mAct][r]);
                mMatIn    = streamQ[0];
                mMatValid = 1;
            end else if (bus.RD_EN) begin
                mMatIn    = mBank[mAct][bus.SEQ_DATC];
                mMatValid = 1;
            end else if (bus.MAT_READY) begin
                mMatValid = 0;
            end
            if ((bus.SWAP || mPend) && idleFree && !bus.STRM_START) begin
                nextAct = !mAct;
                mPend   = 0;
            end else if (bus.SWAP) begin
                mPend = 1;
            end
            if (bus.WR_EN) mBank[!mAct][bus.WR_ROW] = bus.WR_DATA;
            if (bus.INS_RD) mInsOut = mIns[bus.SEQ_INS];
            mInsValid = bus.INS_RD;
            if (bus.INS_WE) mIns[bus.INS_WADDR] = bus.INS_WDATA;
            mAct = nextAct;
        end
    endtask

    task automatic checkOutput(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        numAsserts++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        bus.WR_EN = 0; bus.WR_ROW = '0; bus.WR_DATA = '0;
        bus.INS_WE = 0; bus.INS_WADDR = '0; bus.INS_WDATA = '0;
        bus.SEQ_DATC = '0; bus.RD_EN = 0; bus.SEQ_INS = '0; bus.INS_RD = 0;
        bus.SWAP = 0; bus.STRM_START = 0; bus.MAT_READY = 0;
    endtask

    task automatic applyStimulus();
        reset          = ($urandom_range(0, 499) == 0);
        bus.WR_EN      = ($urandom_range(0, 1) == 1);
        bus.WR_ROW     = RW'($urandom_range(0, ROWS - 1));
        for (int l = 0; l < N; l++) bus.WR_DATA[l] = $urandom();
        bus.INS_WE     = ($urandom_range(0, 2) == 0);
        bus.INS_WADDR  = IW'($urandom_range(0, 7));
        bus.INS_WDATA  = $urandom();
        bus.INS_RD     = ($urandom_range(0, 2) == 0);
        bus.SEQ_INS    = IW'($urandom_range(0, 7));
        bus.RD_EN      = ($urandom_range(0, 4) == 0);
        bus.SEQ_DATC   = RW'($urandom_range(0, ROWS - 1));
        bus.STRM_START = ($urandom_range(0, 19) == 0);
        bus.SWAP       = ($urandom_range(0, 14) == 0);
        bus.MAT_READY  = ($urandom_range(0, 9) < 7);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            modelStep();
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (checkEn) begin
                checkOutput("MAT_IN", bus.MAT_IN, mMatIn);
                checkOutput("MAT_VALID", bus.MAT_VALID, mMatValid);
                checkOutput("STRM_BUSY", bus.STRM_BUSY, streamQ.size() != 0);
                checkOutput("STRM_DONE", bus.STRM_DONE, mDone);
                checkOutput("ACT_BANK", bus.ACT_BANK, mAct);
                checkOutput("INS_VALID", bus.INS_VALID, mInsValid);
                checkOutput("INS_OUT", bus.INS_OUT, mInsOut);
            end
        end
    end

    initial begin
        clearInputs();
        reset = 1;
        @(posedge clock);
        checkEn = 1;
        @(negedge clock);
        @(negedge clock);
        checkOutput("reset MAT_VALID", bus.MAT_VALID, 0);
        checkOutput("reset STRM_BUSY", bus.STRM_BUSY, 0);
        checkOutput("reset ACT_BANK", bus.ACT_BANK, 0);
        checkOutput("reset INS_OUT", bus.INS_OUT, 0);
        reset = 0;

        bus.RD_EN = 1; bus.SEQ_DATC = RW'(3);
        @(negedge clock);
        bus.RD_EN = 0;
        checkOutput("read after reset", bus.MAT_IN, 0);
        checkOutput("read after reset valid", bus.MAT_VALID, 1);
        bus.MAT_READY = 1;
        @(negedge clock);
        checkOutput("valid drop on ready", bus.MAT_VALID, 0);

        for (int r = 0; r < ROWS; r++) begin
            bus.WR_EN = 1; bus.WR_ROW = RW'(r); bus.WR_DATA = fillRow(32'd5);
            @(negedge clock);
        end
        bus.WR_EN = 0; bus.SWAP = 1;
        @(negedge clock);
        bus.SWAP = 0;
        checkOutput("swap ACT_BANK", bus.ACT_BANK, 1);
        bus.RD_EN = 1; bus.SEQ_DATC = RW'(1);
        @(negedge clock);
        bus.RD_EN = 0;
        checkOutput("swapped row", bus.MAT_IN, fillRow(32'd5));

        bus.INS_WE = 1; bus.INS_WADDR = IW'(1); bus.INS_WDATA = 32'd8;
        @(negedge clock);
        bus.INS_WE = 0; bus.INS_RD = 1; bus.SEQ_INS = IW'(1);
        @(negedge clock);
        bus.INS_RD = 0;
        checkOutput("ins read", bus.INS_OUT, 32'd8);
        checkOutput("ins valid", bus.INS_VALID, 1);
        bus.INS_WE = 1; bus.INS_WDATA = 32'd9; bus.INS_RD = 1;
        @(negedge clock);
        bus.INS_WE = 0; bus.INS_RD = 0;
        checkOutput("ins read-during-write", bus.INS_OUT, 32'd8);
        bus.INS_RD = 1;
        @(negedge clock);
        bus.INS_RD = 0;
        checkOutput("ins new word", bus.INS_OUT, 32'd9);
        @(negedge clock);
        checkOutput("ins valid pulse", bus.INS_VALID, 0);

        for (int r = 0; r < ROWS; r++) begin
            bus.WR_EN = 1; bus.WR_ROW = RW'(r); bus.WR_DATA = fillRow(W'(r + 1));
            @(negedge clock);
        end
        bus.WR_EN = 0; bus.SWAP = 1;
        @(negedge clock);
        bus.SWAP = 0;
        checkOutput("swap back", bus.ACT_BANK, 0);

        bus.STRM_START = 1;
        for (int b = 1; b <= ROWS; b++) begin
            @(negedge clock);
            bus.STRM_START = 0;
            checkOutput("stream beat", bus.MAT_IN, fillRow(W'(b)));
            checkOutput("stream valid", bus.MAT_VALID, 1);
        end
        @(negedge clock);
        checkOutput("stream done", bus.STRM_DONE, 1);
        checkOutput("stream idle", bus.STRM_BUSY, 0);
        @(negedge clock);
        checkOutput("done pulse width", bus.STRM_DONE, 0);

        bus.STRM_START = 1;
        for (int b = 1; b <= 5; b++) begin
            @(negedge clock);
            bus.STRM_START = 0;
            checkOutput("bp beat", bus.MAT_IN, fillRow(W'(b)));
        end
        bus.MAT_READY = 0; bus.SWAP = 1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clock);
            bus.SWAP = (s == 0);
            checkOutput("bp hold", bus.MAT_IN, fillRow(32'd5));
            checkOutput("bp bank held", bus.ACT_BANK, 0);
        end
        bus.MAT_READY = 1;
        for (int b = 6; b <= ROWS; b++) begin
            @(negedge clock);
            checkOutput("bp beat", bus.MAT_IN, fillRow(W'(b)));
            checkOutput("pending bank held", bus.ACT_BANK, 0);
        end
        @(negedge clock);
        checkOutput("bp done", bus.STRM_DONE, 1);
        checkOutput("swap still pending", bus.ACT_BANK, 0);
        @(negedge clock);
        checkOutput("pending swap applied", bus.ACT_BANK, 1);
        @(negedge clock);
        checkOutput("single toggle", bus.ACT_BANK, 1);

        bus.STRM_START = 1;
        for (int b = 1; b <= 7; b++) begin
            @(negedge clock);
            bus.STRM_START = 0;
        end
        reset = 1;
        @(negedge clock);
        reset = 0;
        checkOutput("abort valid", bus.MAT_VALID, 0);
        checkOutput("abort busy", bus.STRM_BUSY, 0);
        checkOutput("abort done", bus.STRM_DONE, 0);
        @(negedge clock);
        checkOutput("abort no done", bus.STRM_DONE, 0);

        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            @(negedge clock);
        end
        reset = 0;
        clearInputs();
        repeat (4) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
        $finish;
    end

endmodule

// File: doc/regfile_cr_banked.md
Name: regfile_cr_banked

Overview:
- Next-generation parametrised register file for the SIMD core, holding matrix operand rows and the instruction store.
- Data region is double-banked. Loads go to the shadow bank while the compute array reads the active bank. A SWAP pulse exchanges the two banks.
- Adds a streaming sequencer that pushes every row of the active bank to the matrix unit under valid/ready backpressure.
- Also provides a registered manual row read and a registered instruction read port.

Parameters:
- N, 16, lanes per row (words delivered to the matrix unit per beat)
- W, 32, word width in bits
- REGN, 512, total words in the instruction region plus one data bank
- B_START, 256, words per data bank; ROWS = B_START/N rows per bank; instruction depth IDEP = REGN-B_START
- Legality: B_START must be a multiple of N, and ROWS and IDEP must each be at least 2. Check with an elaboration-time assertion.

Ports:
- CLK  in  1  clock, all logic on rising edge
- RSTN  in  1  synchronous, active-high reset (asserted = 1)
- WR_EN  in  1  write the row WR_DATA into the shadow bank at WR_ROW
- WR_ROW  in  clog2(ROWS)  shadow row index
- WR_DATA  in  N*W  packed [N-1:0][W-1:0] row data
- INS_WE  in  1  instruction write strobe
- INS_WADDR  in  clog2(IDEP)  instruction write address
- INS_WDATA  in  W  instruction word
- SEQ_DATC  in  clog2(ROWS)  manual read row (active bank)
- RD_EN  in  1  manual row read request
- SEQ_INS  in  clog2(IDEP)  instruction read address
- INS_RD  in  1  instruction read request
- SWAP  in  1  exchange active and shadow banks
- STRM_START  in  1  start streaming all active rows
- MAT_READY  in  1  consumer ready
- MAT_IN  out  N*W  row delivered to the matrix unit
- MAT_VALID  out  1  MAT_IN valid
- INS_OUT  out  W  instruction word
- INS_VALID  out  1  INS_OUT valid (one-cycle pulse)
- STRM_BUSY  out  1  sequencer not IDLE
- STRM_DONE  out  1  one-cycle pulse after the last streamed beat
- ACT_BANK  out  1  index of the active bank

Behaviour:
Reset (RSTN = 1 at an edge):
- All storage is cleared to 0.
- MAT_IN = 0, MAT_VALID = 0, INS_OUT = 0, INS_VALID = 0, STRM_BUSY = 0, STRM_DONE = 0, ACT_BANK = 0.
- FSM goes to IDLE and the pending-swap flag clears.
- Reset mid-stream aborts the stream with no DONE pulse.

Writes:
- WR_EN writes the shadow bank (the bank not equal to ACT_BANK) at the edge. Writes are accepted in any state.
- INS_WE writes the instruction store at the edge.

Instruction read:
- INS_RD at edge t gives INS_OUT = mem[SEQ_INS] at t+1, with INS_VALID high for one cycle.
- INS_OUT holds its value between reads.
- Read and write to the same address in the same cycle return the old word.

FSM states are IDLE, STREAM and LAST.

IDLE:
- RD_EN loads MAT_IN = active[SEQ_DATC] and sets MAT_VALID, latency 1 cycle.
- MAT_VALID stays high until a cycle with MAT_READY = 1, then drops unless a new RD_EN occurs in that same cycle.
- STRM_START takes priority over RD_EN. It loads row 0, sets MAT_VALID, and moves to STREAM, or to LAST if ROWS = 1.

STREAM:
- Row counter cnt starts at 0.
- On MAT_VALID && MAT_READY: cnt++ and MAT_IN = active[cnt+1].
- When cnt+1 = ROWS-1, move to LAST.
- With MAT_READY = 0, MAT_IN and cnt hold.

LAST:
- On handshake: MAT_VALID = 0, STRM_DONE pulses, return to IDLE.

SWAP handling:
- In IDLE with no outstanding MAT_VALID: ACT_BANK toggles at the edge.
- Otherwise: set swap_pend. The toggle happens on the first cycle in IDLE with MAT_VALID = 0 and then swap_pend clears.
- A second SWAP while pending is absorbed (no double toggle).

Other rules:
- RD_EN and STRM_START are ignored while STRM_BUSY = 1.
- A shadow write during streaming does not disturb the streamed data.
- Row and instruction indices are unsigned and need no wrap, because their widths exactly cover the ranges.

Decomposition:
- Package regfile_cr_pkg holds:
  - the typedef of state_e {IDLE, STREAM, LAST}
  - the parameterised row type via the N/W localparams
  - the ROWS and IDEP derivation helpers
- One natural sub-module, regfile_cr_seq: the FSM, row counter, handshake and swap_pend. Storage and the read muxes stay in the top level.

Test Plan:
- Reset: hold RSTN = 1 for 2 cycles -> all outputs 0 and ACT_BANK = 0; after release, RD_EN row 3 -> MAT_IN all 0.
- Bank swap: write rows 0..15 of the shadow bank with the value 5, SWAP, then RD_EN SEQ_DATC = 1 -> MAT_IN = {16{32'd5}} one cycle later and ACT_BANK = 1.
- Instruction path: INS_WE addr 1 = 32'd8, then INS_RD SEQ_INS = 1 -> INS_OUT = 8 with a one-cycle INS_VALID.
  - Also issue a same-cycle write 9 and read at addr 1 -> old value 8 returned.
- Stream, no backpressure: rows hold value row+1, STRM_START, MAT_READY = 1 -> 16 consecutive beats with values 1..16, STRM_DONE on the cycle after beat 16, then STRM_BUSY = 0.
- Backpressure and pending swap:
  - Drop MAT_READY for 3 cycles at beat 4 -> MAT_IN holds value 5.
  - A SWAP issued mid-stream leaves ACT_BANK unchanged until after DONE, then it toggles exactly once.
- Reset mid-stream: assert RSTN at beat 7 -> next cycle MAT_VALID = 0, STRM_BUSY = 0, and no STRM_DONE pulse.
